int_to_str: RTL

Sequential binary-to-ASCII decimal formatter: it converts an unsigned 32-bit integer into four packed ASCII digit characters. It is the transmit-side counterpart of the four-character ASCII-to-integer parser, and its output packs the characters in the same order as the parser's input. It sits between arithmetic results and the character/display path. Conversion is iterative shift-add-3 (double dabble) with valid/ready handshakes on both sides.

---
 rtl/int_to_str.sv | 115 +++++++++++
 1 files changed

// File: rtl/int_to_str.sv
// Iterative double-dabble formatter: 32-bit unsigned value to four packed ASCII digits.
// Optional leading-zero blanking when INT_TO_STR_BLANK_EN is defined.
module int_to_str (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] val,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] buffer,
   output logic        ovf
);

   typedef enum logic [1:0] {IDLE, SHIFT, PACK, DONE} state_t;

`ifdef INT_TO_STR_BLANK_EN
   localparam logic [31:0] ZERO_STR = 32'h20202030;
`else
   localparam logic [31:0] ZERO_STR = 32'h30303030;
`endif

   state_t      state, state_nxt;
   logic [13:0] bin;
   logic [15:0] bcd;
   logic [3:0]  cnt;
   logic        ovf_pend;

   function automatic logic [15:0] add3(input logic [15:0] b);
      logic [15:0] r;
      r = b;
      for (int i = 0; i < 4; i++) begin
         if (b[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   function automatic logic [31:0] pack(input logic [15:0] b, input logic o);
      logic [31:0] r;
`ifdef INT_TO_STR_BLANK_EN
      logic        lead;
`endif
      r = 32'h39393939;
      if (!o) begin
         for (int i = 0; i < 4; i++)
            r[8*i +: 8] = {4'h3, b[4*i +: 4]};
`ifdef INT_TO_STR_BLANK_EN
         // Blank leading zeros from the thousands digit down; units always shown.
         lead = 1'b1;
         for (int i = 3; i >= 1; i--) begin
            if (lead && (b[4*i +: 4] == 4'd0))
               r[8*i +: 8] = 8'h20;
            else
               lead = 1'b0;
         end
`endif
      end
      return r;
   endfunction

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = SHIFT;
         SHIFT:   if (cnt == 4'd0) state_nxt = PACK;
         PACK:    state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Conversion datapath: needs no reset, always reloaded on accept.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: if (in_valid) begin
            bin      <= val[13:0];
            bcd      <= 16'd0;
            cnt      <= 4'd13;
            ovf_pend <= (val > 32'd9999);
         end
         SHIFT: begin
            {bcd, bin} <= {add3(bcd), bin} << 1;
            cnt        <= cnt - 4'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buffer    <= ZERO_STR;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (state == PACK) begin
            buffer    <= pack(bcd, ovf_pend);
            ovf       <= ovf_pend;
            out_valid <= 1'b1;
         end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
